memory_n_to_1_arbiter: RTL
==========================

// Module: memory_n_to_1_arbiter
// PURPOSE
//  Shares one single-port memory of NUM_CH*SINGLE_MEM_DEPTH words among NUM_CH client channels.
//  Each channel sees a private window of SINGLE_MEM_DEPTH words; window i starts at i*SINGLE_MEM_DEPTH.
//  A round-robin arbiter with optional per-channel lock serves one access per cycle.
//  Read data returns tagged with the originating channel. Out-of-range accesses are flagged.
//  Sits between the top controller's operand clients and the shared operand RAM.
// PARAMETERS
//  WIDTH                 64   data word width
//  NUM_CH                4    number of client channels (>=2)
//  SINGLE_MEM_DEPTH      7    words per channel window
//  SINGLE_MEM_DEPTH_LOG  `CLOG2(SINGLE_MEM_DEPTH)  per-channel address width
//  FULL_MEM_DEPTH        NUM_CH*SINGLE_MEM_DEPTH   physical memory depth
//  FULL_MEM_DEPTH_LOG    `CLOG2(FULL_MEM_DEPTH)    physical address width
//  CH_LOG                `CLOG2(NUM_CH) (min 1)     channel index width
// PORTS
//  clk        in   1                     single clock, all logic on rising edge
//  rst_n      in   1                     asynchronous active-low reset
//  req        in   NUM_CH                per-channel request; held until granted
//  req_we     in   NUM_CH                1=write, 0=read (per channel, valid with req)
//  req_lock   in   NUM_CH                keep grant on this channel while its req stays high
//  req_addr   in   NUM_CH*SINGLE_MEM_DEPTH_LOG  per-channel local address, ch i at [i*SMDL +: SMDL]
//  req_din    in   NUM_CH*WIDTH          per-channel write data, ch i at [i*WIDTH +: WIDTH]
//  gnt        out  NUM_CH                one-hot grant, combinational, same cycle as accepted req
//  rd_valid   out  1                     read data valid
//  rd_ch      out  CH_LOG                channel owning rd_dout
//  rd_dout    out  WIDTH                 read data
//  err_oor    out  1                     sticky: an out-of-range access was granted
//  err_clr    in   1                     synchronous clear of err_oor
// BEHAVIOUR
//  Reset: rr_ptr=0, lock_owner invalid, rd_valid=0, rd_ch=0, err_oor=0; memory contents untouched.
//  Arbitration (per cycle, at most one grant):
//   - if lock_owner valid and req[lock_owner]=1: grant lock_owner.
//   - else grant first i with req[i]=1 searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_CH.
//   - no req: gnt=0, memory idle (wr_en=0).
//  On grant of ch g: rr_ptr <= (g+1) mod NUM_CH; lock_owner <= g if req_lock[g] else invalid.
//   Locked channel dropping req releases lock same cycle; arbitration falls to round-robin.
//  Address: phys = g*SINGLE_MEM_DEPTH + req_addr[g], computed in FULL_MEM_DEPTH_LOG bits.
//  Out of range (req_addr[g] >= SINGLE_MEM_DEPTH): grant still issued (client unblocks),
//   write suppressed, read returns rd_valid with rd_dout=0; err_oor <= 1.
//  err_clr and new OOR event same cycle: err_oor stays 1 (set wins).
//  Write: memory written at grant edge T; a read granted at T+1 to same phys addr sees new data.
//  Read latency: granted at cycle T -> rd_valid=1, rd_ch=g, rd_dout valid at cycle T+1,
//   held one cycle only; back-to-back reads give rd_valid every cycle. Writes never assert rd_valid.
//  Memory: single_port_mem, depth FULL_MEM_DEPTH, 1-cycle registered read.
//  Reset asserted mid-read: rd_valid drops immediately (async); in-flight read is lost.
// TESTING
//  1 Reset: rst_n=0 with req=4'b1111 -> gnt irrelevant-free check: rd_valid=0, err_oor=0;
//    after release first grant = ch0.
//  2 Round-robin: all 4 ch req reads continuously -> gnt sequence 0,1,2,3,0;
//    rd_ch one cycle behind each grant.
//  3 Windows: ch1 writes 0xAAAA at addr 3, ch2 writes 0xBBBB at addr 3 -> ch1 reads 0xAAAA,
//    ch2 reads 0xBBBB (phys 10, 17).
//  4 Lock: ch2 req+lock 5 cycles while ch0,ch3 request -> gnt=ch2 x5, then ch3, then ch0.
//  5 OOR: ch0 read addr 7 (DEPTH=7) -> gnt, rd_valid next cycle with 0, err_oor=1;
//    err_clr -> 0; phys 7 contents unchanged.
//  6 RAW: ch3 writes 0x1234 addr 0 at T, ch0 reads ch3 window? no: ch3 reads addr 0 at T+1 -> 0x1234.

Source files
------------

// File: rtl/memory_n_to_1_arbiter.sv
// Shares one single-port RAM among NUM_CH clients, each with a private window and a round-robin or locked grant.
// Latency: the grant is combinational in the request cycle. Read data and its channel tag follow one cycle later.
// Backpressure: a client holds req until it sees gnt. Only one access is served per cycle.

module single_port_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 28,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive reset by design; only the read register sees traffic.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= din;
            else
                dout <= mem[addr];
        end
    end
endmodule

module memory_n_to_1_arbiter #(
    parameter int WIDTH            = 64,
    parameter int NUM_CH           = 4,
    parameter int SINGLE_MEM_DEPTH = 7
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_CH-1:0]                        req,
    input  logic [NUM_CH-1:0]                        req_we,
    input  logic [NUM_CH-1:0]                        req_lock,
    input  logic [NUM_CH*$clog2(SINGLE_MEM_DEPTH)-1:0] req_addr,
    input  logic [NUM_CH*WIDTH-1:0]                  req_din,
    output logic [NUM_CH-1:0]                        gnt,
    output logic                                     rd_valid,
    output logic [(($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH))-1:0] rd_ch,
    output logic [WIDTH-1:0]                         rd_dout,
    output logic                                     err_oor,
    input  logic                                     err_clr
);
    localparam int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH);
    localparam int FULL_MEM_DEPTH       = NUM_CH * SINGLE_MEM_DEPTH;
    localparam int FULL_MEM_DEPTH_LOG   = $clog2(FULL_MEM_DEPTH);
    localparam int CH_LOG               = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH);
    localparam int SMDL                 = SINGLE_MEM_DEPTH_LOG;

    logic [CH_LOG-1:0]             rr_ptr;
    logic                          lock_vld;
    logic [CH_LOG-1:0]             lock_owner;
    logic                          oor_q;

    logic                          gnt_any;
    logic [CH_LOG-1:0]             gnt_ch;
    logic [CH_LOG-1:0]             idx;
    logic [SMDL-1:0]               local_addr;
    logic                          oor;
    logic [FULL_MEM_DEPTH_LOG-1:0] base_addr;
    logic [FULL_MEM_DEPTH_LOG-1:0] phys_addr;
    logic                          gnt_we;
    logic [WIDTH-1:0]              gnt_din;
    logic                          mem_en;
    logic [WIDTH-1:0]              mem_dout;

    // A held lock beats round-robin; a locked client dropping req frees the slot at once.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        if (lock_vld && req[lock_owner]) begin
            gnt_any = 1'b1;
            gnt_ch  = lock_owner;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = CH_LOG'((int'(rr_ptr) + k) % NUM_CH);
                if (!gnt_any && req[idx]) begin
                    gnt_any = 1'b1;
                    gnt_ch  = idx;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any)
            gnt[gnt_ch] = 1'b1;
    end

    // Widen by one bit so a power-of-two window depth still compares correctly.
    always_comb begin
        local_addr = req_addr[int'(gnt_ch)*SMDL +: SMDL];
        oor        = ({1'b0, local_addr} >= (SMDL+1)'(SINGLE_MEM_DEPTH));
        base_addr  = FULL_MEM_DEPTH_LOG'(int'(gnt_ch) * SINGLE_MEM_DEPTH);
        phys_addr  = base_addr + FULL_MEM_DEPTH_LOG'(local_addr);
        gnt_we     = req_we[gnt_ch];
        gnt_din    = req_din[int'(gnt_ch)*WIDTH +: WIDTH];
        mem_en     = gnt_any && !oor;
    end

    single_port_mem #(
        .WIDTH (WIDTH),
        .DEPTH (FULL_MEM_DEPTH),
        .AW    (FULL_MEM_DEPTH_LOG)
    ) u_mem (
        .clk  (clk),
        .en   (mem_en),
        .we   (gnt_we),
        .addr (phys_addr),
        .din  (gnt_din),
        .dout (mem_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            lock_vld   <= 1'b0;
            lock_owner <= '0;
            rd_valid   <= 1'b0;
            rd_ch      <= '0;
            oor_q      <= 1'b0;
            err_oor    <= 1'b0;
        end else begin
            rd_valid <= gnt_any && !gnt_we;
            if (gnt_any) begin
                rr_ptr     <= (gnt_ch == CH_LOG'(NUM_CH-1)) ? '0 : gnt_ch + 1'b1;
                lock_vld   <= req_lock[gnt_ch];
                lock_owner <= gnt_ch;
                if (!gnt_we) begin
                    rd_ch <= gnt_ch;
                    oor_q <= oor;
                end
            end else begin
                lock_vld <= 1'b0;
            end
            // A new out-of-range grant outranks a simultaneous clear.
            if (gnt_any && oor)
                err_oor <= 1'b1;
            else if (err_clr)
                err_oor <= 1'b0;
        end
    end

    // The RAM holds its last read word, so out-of-range reads are zeroed here.
    assign rd_dout = oor_q ? '0 : mem_dout;
endmodule
